// File: rtl/wm_min_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : wm_min_scanner_if
// Brief    : Controller / working-memory bundle for the minimum-distance scanner.
// Revision : 1.0
// ============================================================================
interface wm_min_scanner_if #(
  parameter int ADDR_W = 13,
  parameter int NODE_W = 8,
  parameter int DIST_W = 64
);
  logic              start;
  logic [NODE_W-1:0] node_count;
  logic [ADDR_W-1:0] base_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [127:0]      rd_data;
  logic              mark_valid;
  logic [NODE_W-1:0] mark_node;
  logic              clear_visited;
  logic              busy;
  logic              done;
  logic              found;
  logic [NODE_W-1:0] min_node;
  logic [ADDR_W-1:0] min_addr;
  logic [DIST_W-1:0] min_dist;

  modport master (
    output start, node_count, base_addr, rd_data, mark_valid, mark_node, clear_visited,
    input  rd_en, rd_addr, busy, done, found, min_node, min_addr, min_dist
  );

  modport slave (
    input  start, node_count, base_addr, rd_data, mark_valid, mark_node, clear_visited,
    output rd_en, rd_addr, busy, done, found, min_node, min_addr, min_dist
  );
endinterface
`default_nettype wire

// File: rtl/wm_min_scanner.sv
`default_nettype none
// ============================================================================
// Module   : wm_min_scanner
// Brief    : Scans working-memory distances and returns the unvisited node with
//            the smallest finite signed distance; owns the visited bitmap.
//            Optional macro WM_SCAN_AUTOMARK_EN marks the winner on completion.
// Revision : 1.0
// ============================================================================
module wm_min_scanner #(
  parameter int ADDR_W = 13,
  parameter int NODE_W = 8,
  parameter int DIST_W = 64
) (
  input  wire logic       clock,
  input  wire logic       reset_n,
  wm_min_scanner_if.slave bus
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic signed [DIST_W-1:0] c_dist_max = {1'b0, {(DIST_W-1){1'b1}}};

  logic [1:0]                r_state;
  logic [NODE_W-1:0]         r_count;
  logic [NODE_W-1:0]         r_idx;
  logic [ADDR_W-1:0]         r_base;
  logic                      r_cmp_valid;
  logic [NODE_W-1:0]         r_cmp_idx;
  logic                      r_found;
  logic [NODE_W-1:0]         r_min_node;
  logic [ADDR_W-1:0]         r_min_addr;
  logic signed [DIST_W-1:0]  r_min_dist;
  logic [(2**NODE_W)-1:0]    r_visited;

  logic                      w_accept;
  logic                      w_rd_en;
  logic signed [DIST_W-1:0]  w_cand;
  logic                      w_eligible;
  logic                      w_automark;
  logic                      w_unused_rd_lsbs;

  assign w_accept = (r_state == c_st_idle) && bus.start;
  assign w_rd_en  = (r_state == c_st_issue);
  assign w_cand   = bus.rd_data[127 -: DIST_W];
  assign w_unused_rd_lsbs = ^bus.rd_data[127-DIST_W:0];

  // Visited bit is read as it stands when the datum arrives; a same-cycle mark lands afterwards.
  assign w_eligible = r_cmp_valid && !r_visited[r_cmp_idx] &&
                      (w_cand != c_dist_max) && (w_cand < r_min_dist);

`ifdef WM_SCAN_AUTOMARK_EN
  assign w_automark = (r_state == c_st_done) && r_found;
`else
  assign w_automark = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
      r_count <= '0;
      r_idx   <= '0;
      r_base  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (bus.start) begin
            if (bus.node_count == '0) begin
              r_state <= c_st_done;
            end else begin
              r_state <= c_st_issue;
              r_count <= bus.node_count;
              r_base  <= bus.base_addr;
              r_idx   <= '0;
            end
          end
        end
        c_st_issue: begin
          if (r_idx == r_count - NODE_W'(1)) begin
            r_state <= c_st_drain;
          end else begin
            r_idx <= r_idx + NODE_W'(1);
          end
        end
        c_st_drain: r_state <= c_st_done;
        default:    r_state <= c_st_idle;
      endcase
    end
  end

  // Compare stage tracks which index the returning datum belongs to.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cmp_valid <= 1'b0;
      r_cmp_idx   <= '0;
    end else begin
      r_cmp_valid <= w_rd_en;
      r_cmp_idx   <= r_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_found    <= 1'b0;
      r_min_node <= '0;
      r_min_addr <= '0;
      r_min_dist <= c_dist_max;
    end else if (w_accept) begin
      r_found    <= 1'b0;
      r_min_node <= '0;
      r_min_addr <= '0;
      r_min_dist <= c_dist_max;
    end else if (w_eligible) begin
      r_found    <= 1'b1;
      r_min_node <= r_cmp_idx;
      r_min_addr <= r_base + ADDR_W'(r_cmp_idx);
      r_min_dist <= w_cand;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_visited <= '0;
    end else if (bus.clear_visited) begin
      r_visited <= '0;
    end else begin
      if (bus.mark_valid) r_visited[bus.mark_node] <= 1'b1;
      if (w_automark)     r_visited[r_min_node]    <= 1'b1;
    end
  end

  assign bus.rd_en    = w_rd_en;
  assign bus.rd_addr  = r_base + ADDR_W'(r_idx);
  assign bus.busy     = (r_state == c_st_issue) || (r_state == c_st_drain);
  assign bus.done     = (r_state == c_st_done);
  assign bus.found    = r_found;
  assign bus.min_node = r_min_node;
  assign bus.min_addr = r_min_addr;
  assign bus.min_dist = r_min_dist;

endmodule
`default_nettype wire

// File: tb/tb_wm_min_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_wm_min_scanner
// Brief    : Directed + randomized bench for wm_min_scanner with a reference model.
// Revision : 1.0
// ============================================================================
module tb_wm_min_scanner;
  localparam int ADDR_W = 13;
  localparam int NODE_W = 8;
  localparam int DIST_W = 64;
  localparam logic [63:0] c_dmax = 64'h7FFF_FFFF_FFFF_FFFF;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [127:0] mem [0:8191];
  bit           vis [0:255];

  wm_min_scanner_if #(.ADDR_W(ADDR_W), .NODE_W(NODE_W), .DIST_W(DIST_W)) bus ();

  wm_min_scanner #(.ADDR_W(ADDR_W), .NODE_W(NODE_W), .DIST_W(DIST_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Working memory: one-cycle read latency.
  always @(posedge clock) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setd(input logic [12:0] a, input longint d);
    mem[a] = {d[63:0], $urandom, $urandom};
  endtask

  task automatic clear_vis_model();
    foreach (vis[i]) vis[i] = 1'b0;
  endtask

  task automatic do_mark(input int node);
    bus.mark_valid = 1'b1;
    bus.mark_node  = node[7:0];
    @(negedge clock);
    bus.mark_valid = 1'b0;
    vis[node] = 1'b1;
  endtask

  task automatic do_clear();
    bus.clear_visited = 1'b1;
    @(negedge clock);
    bus.clear_visited = 1'b0;
    clear_vis_model();
  endtask

  // Reference: lowest-index strict minimum over unvisited, finite signed distances.
  task automatic model(input int n, input logic [12:0] base,
                       output bit f, output int node, output longint best);
    f = 0; node = 0; best = longint'(c_dmax);
    for (int j = 0; j < n; j++) begin
      logic [12:0] a;
      longint dj;
      a  = base + 13'(j);
      dj = longint'(mem[a][127:64]);
      if (!vis[j] && dj != longint'(c_dmax) && dj < best) begin
        f = 1; node = j; best = dj;
      end
    end
  endtask

  // midop: 0 none, 1 start pulse while busy, 2 clear+mark(2) same cycle early,
  //        3 mark(2) in the cycle node 2's datum is compared.
  task automatic run_scan(input int n, input logic [12:0] base, input int midop,
                          input string tag, output int res_node);
    int lat, pulses, first_k, bad, k, node;
    bit f;
    longint best;
    logic [12:0] addrs [$];
    logic [12:0] ea;
    bus.start      = 1'b1;
    bus.node_count = n[7:0];
    bus.base_addr  = base;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    lat = -1; pulses = 0; first_k = -1; k = 1;
    while (k <= 600 && lat < 0) begin
      if (bus.rd_en) begin
        pulses++;
        addrs.push_back(bus.rd_addr);
        if (first_k < 0) first_k = k;
      end
      if (bus.done) begin
        lat = k;
        check({tag, "_busy_in_done"}, bus.busy, 1'b0);
      end
      if (midop == 1 && k == 2) begin bus.start = 1'b1; bus.node_count = 8'd0; bus.base_addr = 13'h1ABC; end
      if (midop == 1 && k == 3) bus.start = 1'b0;
      if (midop == 2 && k == 1) begin
        bus.clear_visited = 1'b1; bus.mark_valid = 1'b1; bus.mark_node = 8'd2;
        clear_vis_model();
      end
      if (midop == 2 && k == 2) begin bus.clear_visited = 1'b0; bus.mark_valid = 1'b0; end
      if (midop == 3 && k == 4) begin bus.mark_valid = 1'b1; bus.mark_node = 8'd2; end
      if (midop == 3 && k == 5) bus.mark_valid = 1'b0;
      @(negedge clock);
      k++;
    end
    model(n, base, f, node, best);
    check({tag, "_latency"}, lat, (n == 0) ? 1 : n + 2);
    check({tag, "_rd_pulses"}, pulses, n);
    if (n > 0) begin
      bad = 0;
      foreach (addrs[j]) if (addrs[j] !== base + 13'(j)) bad++;
      check({tag, "_rd_addr_seq"}, bad, 0);
      check({tag, "_first_issue"}, first_k, 1);
    end
    check({tag, "_found"}, bus.found, f);
    if (f) begin
      ea = base + 13'(node);
      check({tag, "_min_node"}, bus.min_node, node[7:0]);
      check({tag, "_min_addr"}, bus.min_addr, ea);
      check({tag, "_min_dist"}, bus.min_dist, best[63:0]);
    end else begin
      check({tag, "_min_dist_max"}, bus.min_dist, c_dmax);
    end
`ifdef WM_SCAN_AUTOMARK_EN
    if (f) vis[node] = 1'b1;
`endif
    if (midop == 3) vis[2] = 1'b1;
    res_node = f ? node : -1;
  endtask

  initial begin
    int r0, r1, n, seen_done, op;
    logic [12:0] base;
    bus.start = 0; bus.node_count = 0; bus.base_addr = 0;
    bus.mark_valid = 0; bus.mark_node = 0; bus.clear_visited = 0;
    foreach (mem[i]) mem[i] = 128'd0;
    clear_vis_model();

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_rd_en", bus.rd_en, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_found", bus.found, 1'b0);
    check("rst_min_node", bus.min_node, 8'd0);
    check("rst_min_addr", bus.min_addr, 13'd0);
    check("rst_rd_addr", bus.rd_addr, 13'd0);
    check("rst_min_dist", bus.min_dist, c_dmax);
    reset_n = 1'b1;
    @(negedge clock);

    setd(13'h100, 50); setd(13'h101, 20); setd(13'h102, longint'(c_dmax)); setd(13'h103, 20);
    run_scan(4, 13'h100, 0, "basic", r0);
    check("basic_node_const", r0, 1);
    do_mark(1);
    run_scan(4, 13'h100, 0, "premark", r0);
    check("premark_node_const", r0, 3);
    repeat (3) @(negedge clock);
    check("hold_min_node", bus.min_node, 8'd3);
    check("hold_found", bus.found, 1'b1);

    do_clear();
    for (int j = 0; j < 4; j++) setd(13'h300 + 13'(j), longint'(c_dmax));
    run_scan(4, 13'h300, 0, "all_inf", r0);
    for (int j = 0; j < 4; j++) do_mark(j);
    run_scan(4, 13'h100, 0, "all_visited", r0);
    run_scan(0, 13'h100, 0, "zero", r0);
    do_clear();
    run_scan(4, 13'h100, 1, "start_busy", r0);

    do_clear();
    bus.start = 1'b1; bus.node_count = 8'd4; bus.base_addr = 13'h100;
    @(posedge clock);
    @(negedge clock); bus.start = 1'b0;
    seen_done = bus.done;
    @(negedge clock); seen_done |= bus.done;
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_rd_en", bus.rd_en, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_found", bus.found, 1'b0);
    check("midrst_min_node", bus.min_node, 8'd0);
    check("midrst_min_addr", bus.min_addr, 13'd0);
    check("midrst_rd_addr", bus.rd_addr, 13'd0);
    check("midrst_min_dist", bus.min_dist, c_dmax);
    seen_done |= bus.done;
    reset_n = 1'b1;
    clear_vis_model();
    repeat (8) begin @(negedge clock); seen_done |= bus.done; end
    check("midrst_no_done", seen_done, 0);

    setd(13'h400, 30); setd(13'h401, 25); setd(13'h402, -5); setd(13'h403, 40);
    do_mark(2);
    run_scan(4, 13'h400, 2, "clr_mark_same", r0);
    check("clr_mark_node", r0, 2);
    do_clear();
    run_scan(4, 13'h400, 3, "mark_at_cmp", r0);
    check("mark_at_cmp_node", r0, 2);

    do_clear();
    setd(13'h200, 5); setd(13'h201, 9);
    run_scan(2, 13'h200, 0, "auto1", r0);
    run_scan(2, 13'h200, 0, "auto2", r1);
    check("auto1_node", r0, 0);
`ifdef WM_SCAN_AUTOMARK_EN
    check("auto2_node", r1, 1);
`else
    check("auto2_node", r1, 0);
`endif

    for (int it = 0; it < 25; it++) begin
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
      base = ($urandom_range(0, 3) == 0) ? 13'(8192 - $urandom_range(1, 8)) : 13'($urandom_range(0, 8191));
      for (int j = 0; j < n; j++) begin
        op = $urandom_range(0, 9);
        if (op == 0)      setd(base + 13'(j), longint'(c_dmax));
        else if (op == 1) setd(base + 13'(j), -longint'($urandom_range(1, 100)));
        else              setd(base + 13'(j), longint'($urandom_range(0, 40)));
      end
      if ($urandom_range(0, 4) == 0) do_clear();
      if (n > 0 && $urandom_range(0, 1) == 1) do_mark($urandom_range(0, n - 1));
      run_scan(n, base, (n >= 4) ? int'($urandom_range(0, 3)) : 0, "rand", r0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
